sar_adc_capture_ctrl: RTL

Digital sequencer for the 10b SAR ADC core: programs the ADC mode bits C[3:1], gates conversions, and captures the 11-bit result B[10:0] when the core raises READY. Averages 1/2/4/8 conversions, then presents each result through a one-deep valid/ready output buffer. In single mode it performs one burst per START; in continuous mode it repeats bursts until STOP. Sits between the ADC core and the on-chip consumer, in the digital domain, on the same CLK as the core.

---
 rtl/sar_adc_capture_ctrl_pkg.sv | 30 +++
 rtl/sar_adc_capture_ctrl_if.sv | 39 +++
 rtl/sar_adc_capture_ctrl_ready_sync.sv | 31 +++
 rtl/sar_adc_capture_ctrl.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/sar_adc_capture_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sar_adc_pkg
// Description : Shared state encoding, widths and helpers for the SAR ADC
//               capture controller.
// Revision    : 1.0 - initial release
// ============================================================================
package sar_adc_pkg;

    localparam int ADC_DW           = 11;
    localparam int ADC_CW           = 3;
    localparam int ADC_OSR_MAX_LOG2 = 3;
    localparam int ACC_W            = ADC_DW + ADC_OSR_MAX_LOG2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Clamp the requested averaging exponent to what the accumulator can hold.
    function automatic logic [1:0] sat_osr(input logic [1:0] req, input int unsigned max_log2);
        if (32'(req) > max_log2) begin
            return 2'(max_log2);
        end
        return req;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sar_adc_capture_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : sar_adc_capture_ctrl_if
// Description : Control, ADC-core and result-handshake signals of the capture
//               controller. master = controller side, slave = environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface sar_adc_capture_ctrl_if
    import sar_adc_pkg::*;
#(
    parameter int DW = ADC_DW,
    parameter int CW = ADC_CW
);
    logic          start;
    logic          stop;
    logic          cont;
    logic [CW-1:0] cfg_c;
    logic [1:0]    osr_log2;
    logic [CW-1:0] adc_c;
    logic          adc_en;
    logic [DW-1:0] adc_b;
    logic          adc_ready;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          dout_ready;
    logic          busy;
    logic          overrun;

    modport master (
        input  start, stop, cont, cfg_c, osr_log2, adc_b, adc_ready, dout_ready,
        output adc_c, adc_en, dout, dout_valid, busy, overrun
    );

    modport slave (
        output start, stop, cont, cfg_c, osr_log2, adc_b, adc_ready, dout_ready,
        input  adc_c, adc_en, dout, dout_valid, busy, overrun
    );
endinterface
`default_nettype wire

// File: rtl/sar_adc_capture_ctrl_ready_sync.sv
`default_nettype none
// ============================================================================
// Module      : sar_ready_sync
// Description : Synchronizes the core READY flag and emits a one-cycle pulse
//               on each rising edge of the synchronized level.
// Revision    : 1.0 - initial release
// ============================================================================
module sar_ready_sync #(
    parameter int STAGES = 2
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_async,
    output logic      o_pulse
);
    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_async};
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_pulse = r_sync[STAGES-1] & ~r_prev;
endmodule
`default_nettype wire

// File: rtl/sar_adc_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sar_adc_capture_ctrl
// Description : SAR ADC sequencer - burst control, averaging accumulator and
//               one-deep valid/ready result buffer with sticky overrun.
// Revision    : 1.0 - initial release
// ============================================================================
module sar_adc_capture_ctrl
    import sar_adc_pkg::*;
#(
    parameter int DW           = ADC_DW,
    parameter int CW           = ADC_CW,
    parameter int OSR_MAX_LOG2 = ADC_OSR_MAX_LOG2,
    parameter int SYNC_STAGES  = 2
) (
    input  wire logic              clk,
    input  wire logic              rst,
    sar_adc_capture_ctrl_if.master bus
);
    localparam int c_acc_w = DW + OSR_MAX_LOG2;
    localparam int c_cnt_w = OSR_MAX_LOG2 + 1;

    state_t               r_state;
    logic [CW-1:0]        r_adc_c;
    logic                 r_adc_en;
    logic                 r_cont;
    logic [1:0]           r_osr;
    logic [c_acc_w-1:0]   r_acc;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [DW-1:0]        r_dout;
    logic                 r_dout_valid;
    logic                 r_busy;
    logic                 r_overrun;

    logic                 w_capture;
    logic [c_acc_w-1:0]   w_acc_next;
    logic [c_cnt_w-1:0]   w_cnt_next;
    logic                 w_burst_done;
    logic [DW-1:0]        w_result;
    logic                 w_can_load;

    sar_ready_sync #(
        .STAGES (SYNC_STAGES)
    ) u_ready_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (bus.adc_ready),
        .o_pulse (w_capture)
    );

    assign w_acc_next   = r_acc + c_acc_w'(bus.adc_b);
    assign w_cnt_next   = r_cnt + c_cnt_w'(1);
    assign w_burst_done = (w_cnt_next == (c_cnt_w'(1) << r_osr));
    assign w_result     = DW'(r_acc >> r_osr);
    // Buffer is free if empty or being drained on this very edge.
    assign w_can_load   = !r_dout_valid || bus.dout_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_adc_c      <= '0;
            r_adc_en     <= 1'b0;
            r_cont       <= 1'b0;
            r_osr        <= '0;
            r_acc        <= '0;
            r_cnt        <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            if (r_dout_valid && bus.dout_ready) begin
                r_dout_valid <= 1'b0;
            end

            if (bus.stop) begin
                r_state  <= ST_IDLE;
                r_adc_en <= 1'b0;
                r_busy   <= 1'b0;
                r_acc    <= '0;
                r_cnt    <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (bus.start) begin
                            r_adc_c   <= bus.cfg_c;
                            r_cont    <= bus.cont;
                            r_osr     <= sat_osr(bus.osr_log2, OSR_MAX_LOG2);
                            r_acc     <= '0;
                            r_cnt     <= '0;
                            r_overrun <= 1'b0;
                            r_adc_en  <= 1'b1;
                            r_busy    <= 1'b1;
                            r_state   <= ST_CONV;
                        end
                    end
                    ST_CONV: begin
                        if (w_capture) begin
                            r_acc <= w_acc_next;
                            r_cnt <= w_cnt_next;
                            if (w_burst_done) begin
                                r_state <= ST_DONE;
                            end
                        end
                    end
                    ST_DONE: begin
                        if (w_can_load) begin
                            r_dout       <= w_result;
                            r_dout_valid <= 1'b1;
                        end else begin
                            r_overrun <= 1'b1;
                        end
                        r_acc <= '0;
                        r_cnt <= '0;
                        if (r_cont) begin
                            r_state <= ST_CONV;
                        end else begin
                            r_state  <= ST_IDLE;
                            r_adc_en <= 1'b0;
                            r_busy   <= 1'b0;
                        end
                    end
                    default: begin
                        r_state  <= ST_IDLE;
                        r_adc_en <= 1'b0;
                        r_busy   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.adc_c      = r_adc_c;
    assign bus.adc_en     = r_adc_en;
    assign bus.dout       = r_dout;
    assign bus.dout_valid = r_dout_valid;
    assign bus.busy       = r_busy;
    assign bus.overrun    = r_overrun;
endmodule
`default_nettype wire
